// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate L1 data cache with two-word lines.
// Misses move single words over the memory port; halt writes back every dirty line.
module dcache_dm #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    // state | meaning
    // IDLE  | serve hits, detect misses and halt
    // WB0   | write victim word0 to memory
    // WB1   | write victim word1 to memory
    // LD0   | fetch requested line word0
    // LD1   | fetch requested line word1, then install line
    // FLUSH | inspect line at flush counter
    // FW0   | flush dirty line word0
    // FW1   | flush dirty line word1, then clear dirty
    // DONE  | flush complete, idle until reset

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 32 - IDX - 3;

    typedef enum logic [3:0] {IDLE, WB0, WB1, LD0, LD1, FLUSH, FW0, FW1, DONE} state_t;

    state_t state, next_state;

    logic [SETS-1:0] valid, dirty;
    logic [TAGW-1:0] tag_arr [SETS];
    logic [31:0]     word0   [SETS];
    logic [31:0]     word1   [SETS];
    logic [IDX-1:0]  fcnt;

    logic [TAGW-1:0] req_tag;
    logic [IDX-1:0]  req_idx;
    logic            req_wsel;
    logic            req, tag_match, hit, last_line;
    logic            unused_byte_off;

    assign req_tag         = dmemaddr[31:IDX+3];
    assign req_idx         = dmemaddr[IDX+2:3];
    assign req_wsel        = dmemaddr[2];
    assign unused_byte_off = ^dmemaddr[1:0];
    assign req             = dmemREN | dmemWEN;
    assign tag_match       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign hit             = (state == IDLE) && !halt && req && tag_match;
    assign last_line       = (fcnt == IDX'(SETS - 1));

    always_comb begin
        next_state = state;
        dhit       = hit;
        dmemload   = '0;
        flushed    = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        if (hit)
            dmemload = req_wsel ? word1[req_idx] : word0[req_idx];
        case (state)
            IDLE: begin
                if (halt)
                    next_state = FLUSH;
                else if (req && !tag_match)
                    next_state = (valid[req_idx] && dirty[req_idx]) ? WB0 : LD0;
            end
            WB0: begin
                dWEN   = 1'b1;
                daddr  = {tag_arr[req_idx], req_idx, 3'b000};
                dstore = word0[req_idx];
                if (!dwait) next_state = WB1;
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = {tag_arr[req_idx], req_idx, 3'b100};
                dstore = word1[req_idx];
                if (!dwait) next_state = LD0;
            end
            LD0: begin
                dREN  = 1'b1;
                daddr = {req_tag, req_idx, 3'b000};
                if (!dwait) next_state = LD1;
            end
            LD1: begin
                dREN  = 1'b1;
                daddr = {req_tag, req_idx, 3'b100};
                if (!dwait) next_state = IDLE;
            end
            FLUSH: begin
                if (valid[fcnt] && dirty[fcnt])
                    next_state = FW0;
                else if (last_line)
                    next_state = DONE;
            end
            FW0: begin
                dWEN   = 1'b1;
                daddr  = {tag_arr[fcnt], fcnt, 3'b000};
                dstore = word0[fcnt];
                if (!dwait) next_state = FW1;
            end
            FW1: begin
                dWEN   = 1'b1;
                daddr  = {tag_arr[fcnt], fcnt, 3'b100};
                dstore = word1[fcnt];
                if (!dwait) next_state = last_line ? DONE : FLUSH;
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
            fcnt  <= '0;
        end else begin
            state <= next_state;
            if (hit && dmemWEN)
                dirty[req_idx] <= 1'b1;
            if (state == LD1 && !dwait) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
            end
            if (state == FLUSH && !(valid[fcnt] && dirty[fcnt]) && !last_line)
                fcnt <= fcnt + 1'b1;
            if (state == FW1 && !dwait) begin
                dirty[fcnt] <= 1'b0;
                if (!last_line) fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Line storage carries no reset; valid bits gate every use of it.
    always_ff @(posedge CLK) begin
        if (hit && dmemWEN) begin
            if (req_wsel) word1[req_idx] <= dmemstore;
            else          word0[req_idx] <= dmemstore;
        end
        if (state == LD0 && !dwait)
            word0[req_idx] <= dload;
        if (state == LD1 && !dwait) begin
            word1[req_idx]   <= dload;
            tag_arr[req_idx] <= req_tag;
        end
    end
endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: table of cache requests, bus scoreboard against a memory model,
// plus hand sequences for dwait stalls, reset mid-fill and halt flush.
module tb_dcache_dm;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, halt, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    always #5 CLK = ~CLK;

    dcache_dm #(.SETS(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_load;
        int          lat;
        int          bfirst;
        int          bcount;
    } vec_t;

    bus_t        exp_q[$];
    bus_t        bt[10];
    vec_t        vt[8];
    logic [31:0] mem [bit [31:0]];
    int          stall_cnt = 0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic exp_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_t b;
        b.we = we; b.addr = a; b.data = d;
        exp_q.push_back(b);
    endtask

    // dwait for the current cycle is decided just after the edge
    always @(posedge CLK) begin
        #1;
        if ((dREN || dWEN) && stall_cnt > 0) begin
            dwait = 1'b1;
            stall_cnt--;
        end else begin
            dwait = 1'b0;
        end
    end

    // memory model and bus scoreboard; a transaction completes at the next posedge
    always @(negedge CLK) begin : mon
        bus_t e;
        if (nRST && (dREN || dWEN)) begin
            check(!(dREN && dWEN), "bus_excl", {30'b0, dREN, dWEN}, 32'h1);
            if (dREN) dload = memval(daddr);
            if (!dwait) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "bus_unexpected", daddr, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check(dWEN == e.we && daddr == e.addr, "bus_txn", {dWEN, daddr[30:0]}, {e.we, e.addr[30:0]});
                    if (e.we) check(dstore == e.data, "bus_wdata", dstore, e.data);
                end
                if (dWEN) mem[daddr] = dstore;
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_ld, input int lat, input string nm);
        int  cyc;
        bit  got;
        cyc = 0;
        got = 1'b0;
        dmemREN = !we; dmemWEN = we; dmemaddr = a; dmemstore = d;
        while (cyc < 40) begin
            @(negedge CLK);
            if (dhit) begin got = 1'b1; break; end
            cyc++;
        end
        check(got, {nm, "_hit"}, 32'(got), 32'h1);
        if (got) begin
            check(cyc == lat, {nm, "_lat"}, 32'(cyc), 32'(lat));
            if (!we) check(dmemload == exp_ld, {nm, "_data"}, dmemload, exp_ld);
        end
        @(posedge CLK);
        #2;
        dmemREN = 1'b0; dmemWEN = 1'b0;
        check(exp_q.size() == 0, {nm, "_drain"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({dhit, dREN, dWEN, flushed} == 4'b0, {nm, "_ctl"}, {28'b0, dhit, dREN, dWEN, flushed}, 32'h0);
        check(daddr == 32'h0 && dstore == 32'h0, {nm, "_bus"}, daddr | dstore, 32'h0);
        check(dmemload == 32'h0, {nm, "_load"}, dmemload, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  stalled, k;
        bit  found;

        bt[0] = '{1'b0, 32'h40,  32'h0};
        bt[1] = '{1'b0, 32'h44,  32'h0};
        bt[2] = '{1'b1, 32'h40,  32'h1234_5678};
        bt[3] = '{1'b1, 32'h44,  32'hAAAA_0002};
        bt[4] = '{1'b0, 32'h840, 32'h0};
        bt[5] = '{1'b0, 32'h844, 32'h0};
        bt[6] = '{1'b0, 32'h100, 32'h0};
        bt[7] = '{1'b0, 32'h104, 32'h0};
        bt[8] = '{1'b0, 32'h40,  32'h0};
        bt[9] = '{1'b0, 32'h44,  32'h0};
        //         we    addr        wdata          exp_load       lat bf bc
        vt[0] = '{1'b0, 32'h40,  32'h0,         32'hAAAA_0001, 3, 0, 2};
        vt[1] = '{1'b0, 32'h44,  32'h0,         32'hAAAA_0002, 0, 0, 0};
        vt[2] = '{1'b1, 32'h40,  32'h1234_5678, 32'h0,         0, 0, 0};
        vt[3] = '{1'b0, 32'h840, 32'h0,         32'hC0DE_0840, 5, 2, 4};
        vt[4] = '{1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0,         3, 6, 2};
        vt[5] = '{1'b0, 32'h100, 32'h0,         32'hDEAD_BEEF, 0, 0, 0};
        vt[6] = '{1'b0, 32'h104, 32'h0,         32'hC0DE_0104, 0, 0, 0};
        vt[7] = '{1'b0, 32'h40,  32'h0,         32'h1234_5678, 3, 8, 2};

        mem[32'h40] = 32'hAAAA_0001;
        mem[32'h44] = 32'hAAAA_0002;

        nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
        dmemaddr = '0; dmemstore = '0; dwait = 1'b0; dload = '0;
        repeat (2) @(posedge CLK);
        #1 check_idle_outputs("reset");
        @(posedge CLK);
        #2 nRST = 1'b1;
        @(posedge CLK);
        #2;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < vt[i].bcount; j++) exp_q.push_back(bt[vt[i].bfirst + j]);
            do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_load, vt[i].lat, $sformatf("vec%0d", i));
        end

        // reset while the second fill word is on the bus
        exp_bus(1'b0, 32'hA0, 32'h0);
        exp_bus(1'b0, 32'hA4, 32'h0);
        dmemREN = 1'b1; dmemaddr = 32'hA0;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (dREN && daddr == 32'hA4) begin found = 1'b1; break; end
        end
        check(found, "ld1_reached", 32'(found), 32'h1);
        #2;
        dmemREN = 1'b0;
        nRST = 1'b0;
        #1 check_idle_outputs("rst_mid_fill");
        @(posedge CLK);
        @(posedge CLK);
        #2 nRST = 1'b1;
        check(exp_q.size() == 0, "rst_drain", 32'(exp_q.size()), 32'h0);

        // reload of a previously cached line must miss, with LD0 stalled
        stall_cnt = 5;
        exp_bus(1'b0, 32'h40, 32'h0);
        exp_bus(1'b0, 32'h44, 32'h0);
        dmemREN = 1'b1; dmemaddr = 32'h40;
        stalled = 0;
        found = 1'b0;
        k = 0;
        while (k < 40) begin
            @(negedge CLK);
            if (dhit) begin found = 1'b1; break; end
            if (dwait) begin
                stalled++;
                check(dREN && !dWEN && daddr == 32'h40, "stall_hold", daddr, 32'h40);
            end
            k++;
        end
        check(found, "stall_hit", 32'(found), 32'h1);
        check(stalled == 5, "stall_cycles", 32'(stalled), 32'd5);
        check(k == 8, "stall_lat", 32'(k), 32'd8);
        check(dmemload == 32'h1234_5678, "stall_data", dmemload, 32'h1234_5678);
        @(posedge CLK);
        #2 dmemREN = 1'b0;
        check(exp_q.size() == 0, "stall_drain", 32'(exp_q.size()), 32'h0);

        // dirty lines at index 2 and 15, then flush
        exp_bus(1'b0, 32'h10, 32'h0);
        exp_bus(1'b0, 32'h14, 32'h0);
        do_req(1'b1, 32'h10, 32'h1111_0010, 32'h0, 3, "st10");
        exp_bus(1'b0, 32'h78, 32'h0);
        exp_bus(1'b0, 32'h7C, 32'h0);
        do_req(1'b1, 32'h78, 32'h7878_AAAA, 32'h0, 3, "st78");

        exp_bus(1'b1, 32'h10, 32'h1111_0010);
        exp_bus(1'b1, 32'h14, 32'hC0DE_0014);
        exp_bus(1'b1, 32'h78, 32'h7878_AAAA);
        exp_bus(1'b1, 32'h7C, 32'hC0DE_007C);
        halt = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            if (flushed) begin found = 1'b1; break; end
        end
        check(found, "flush_done", 32'(found), 32'h1);
        check(exp_q.size() == 0, "flush_drain", 32'(exp_q.size()), 32'h0);

        for (int n = 0; n < 4; n++) begin
            @(posedge CLK);
            #2;
            halt = n[0];
            dmemREN = 1'b1;
            dmemaddr = 32'h10;
            @(negedge CLK);
            check(flushed && !dhit && !dREN && !dWEN, "flushed_sticky",
                  {28'b0, flushed, dhit, dREN, dWEN}, 32'h8);
        end
        dmemREN = 1'b0;
        check(exp_q.size() == 0, "final_drain", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
